branch_resolve_ctrl: RTL and testbench

//  Sequences control-flow resolution between ID-stage prediction and EX/MEM resolution.

---
 rtl/brc_pkg.sv | 36 +++
 rtl/brc_fifo.sv | 65 ++++++
 rtl/branch_resolve_ctrl.sv | 173 +++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brc_pkg.sv
// Shared definitions for the branch resolution controller: FSM encoding,
// default parameters and the layout of a queued prediction entry.
package brc_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } brc_state_t;

    localparam int DEFAULT_DEPTH        = 4;
    localparam int DEFAULT_IDX_W        = 3;
    localparam int DEFAULT_XLEN         = 32;
    localparam int DEFAULT_FLUSH_CYCLES = 2;

    // Entry layout, MSB first: {is_jump, taken, idx, target, fallthrough}
    function automatic int entry_width(input int idx_w, input int xlen);
        return 2 * xlen + idx_w + 2;
    endfunction

    function automatic int off_target(input int xlen);
        return xlen;
    endfunction

    function automatic int off_idx(input int xlen);
        return 2 * xlen;
    endfunction

    function automatic int off_taken(input int idx_w, input int xlen);
        return 2 * xlen + idx_w;
    endfunction

    function automatic int off_jump(input int idx_w, input int xlen);
        return 2 * xlen + idx_w + 1;
    endfunction

endpackage

// File: rtl/brc_fifo.sv
// In-order prediction queue: synchronous FIFO with push, pop, clear and
// an occupancy count that saturates at DEPTH.
module brc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop) && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; validity is tracked only by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: queues ID predictions, checks them against
// EX/MEM outcomes, drives predictor update, redirect and flush.
// Optional statistics counters are enabled by defining BRC_STATS_EN.
module branch_resolve_ctrl
    import brc_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int IDX_W        = DEFAULT_IDX_W,
    parameter int XLEN         = DEFAULT_XLEN,
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pred_valid,
    input  logic                   pred_is_jump,
    input  logic                   pred_taken,
    input  logic [IDX_W-1:0]       pred_pht_index,
    input  logic [XLEN-1:0]        pred_target,
    input  logic [XLEN-1:0]        pred_fallthrough,
    output logic                   pred_ready,
    input  logic                   res_valid,
    input  logic                   res_taken,
    input  logic [XLEN-1:0]        res_target,
    output logic                   upd_valid,
    output logic                   upd_taken,
    output logic [IDX_W-1:0]       upd_pht_index,
    output logic                   redirect_valid,
    output logic [XLEN-1:0]        redirect_pc,
    output logic                   flush,
    output logic [$clog2(DEPTH):0] inflight_cnt
`ifdef BRC_STATS_EN
    ,
    output logic [31:0]            stat_branches,
    output logic [31:0]            stat_mispredicts
`endif
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int FC_W    = $clog2(FLUSH_CYCLES + 1);
    localparam int ENTRY_W = entry_width(IDX_W, XLEN);
    localparam int O_TGT   = off_target(XLEN);
    localparam int O_IDX   = off_idx(XLEN);
    localparam int O_TAKEN = off_taken(IDX_W, XLEN);
    localparam int O_JUMP  = off_jump(IDX_W, XLEN);

    brc_state_t        state_q, state_d;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    logic               head_jump;
    logic               head_taken;
    logic [IDX_W-1:0]   head_idx;
    logic [XLEN-1:0]    head_target;
    logic [XLEN-1:0]    head_ft;

    logic               run;
    logic               pop_fire;
    logic               push_fire;
    logic               mispredict;
    logic               mis_fire;

    assign wr_entry = {pred_is_jump, pred_taken, pred_pht_index, pred_target, pred_fallthrough};

    assign head_jump   = head[O_JUMP];
    assign head_taken  = head[O_TAKEN];
    assign head_idx    = head[O_IDX +: IDX_W];
    assign head_target = head[O_TGT +: XLEN];
    assign head_ft     = head[XLEN-1:0];

    assign run       = (state_q == ST_RUN);
    assign pop_fire  = run && res_valid && !fifo_empty;
    // A same-cycle pop frees a slot, so a full queue still takes a push.
    assign pred_ready = run && (!fifo_full || pop_fire);
    assign push_fire = pred_valid && pred_ready;

    assign mispredict = (head_taken != res_taken) || (res_taken && (res_target != head_target));
    assign mis_fire   = pop_fire && mispredict;

    assign inflight_cnt = fifo_count;

    brc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_fire && !mis_fire),
        .pop     (pop_fire && !mis_fire),
        .clear   (mis_fire),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mis_fire) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FC_W'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == FC_W'(1)) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = '0;
            end
        endcase
    end

    // Result outputs are zeroed when not strobed so downstream never sees stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid      <= 1'b0;
            upd_taken      <= 1'b0;
            upd_pht_index  <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush          <= 1'b0;
        end else begin
            upd_valid      <= pop_fire && !head_jump;
            upd_taken      <= pop_fire && !head_jump && res_taken;
            upd_pht_index  <= (pop_fire && !head_jump) ? head_idx : '0;
            redirect_valid <= mis_fire;
            redirect_pc    <= mis_fire ? (res_taken ? res_target : head_ft) : '0;
            flush          <= (state_d == ST_FLUSH);
        end
    end

`ifdef BRC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (pop_fire && !head_jump) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mis_fire) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Testbench for branch_resolve_ctrl: directed vector table, reset corner
// sequences and randomized traffic against a queue-based reference model.
module tb_branch_resolve_ctrl;

    localparam int DEPTH        = 4;
    localparam int IDX_W        = 3;
    localparam int XLEN         = 32;
    localparam int FLUSH_CYCLES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             pred_valid, pred_is_jump, pred_taken;
    logic [IDX_W-1:0] pred_pht_index;
    logic [XLEN-1:0]  pred_target, pred_fallthrough;
    logic             pred_ready;
    logic             res_valid, res_taken;
    logic [XLEN-1:0]  res_target;
    logic             upd_valid, upd_taken;
    logic [IDX_W-1:0] upd_pht_index;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic [2:0]       inflight_cnt;
`ifdef BRC_STATS_EN
    logic [31:0]      stat_branches, stat_mispredicts;
`endif

    branch_resolve_ctrl #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_is_jump(pred_is_jump), .pred_taken(pred_taken),
        .pred_pht_index(pred_pht_index), .pred_target(pred_target),
        .pred_fallthrough(pred_fallthrough), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pht_index(upd_pht_index),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush), .inflight_cnt(inflight_cnt)
`ifdef BRC_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input bit pv, input bit jmp, input bit tk, input bit [2:0] idx,
                              input bit [31:0] tgt, input bit [31:0] ft,
                              input bit rv, input bit rt, input bit [31:0] rtgt);
        pred_valid       = pv;
        pred_is_jump     = jmp;
        pred_taken       = tk;
        pred_pht_index   = idx;
        pred_target      = tgt;
        pred_fallthrough = ft;
        res_valid        = rv;
        res_taken        = rt;
        res_target       = rtgt;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit        is_jump;
        bit        taken;
        bit [2:0]  idx;
        bit [31:0] target;
        bit [31:0] ft;
    } ent_t;

    ent_t      mq[$];
    int        flush_left;
    bit        m_upd_valid, m_upd_taken, m_redir, m_flush;
    bit [2:0]  m_idx;
    bit [31:0] m_pc;
    int        m_branches, m_mispredicts;

    task automatic model_reset();
        mq.delete();
        flush_left    = 0;
        m_upd_valid   = 0;
        m_upd_taken   = 0;
        m_idx         = 0;
        m_redir       = 0;
        m_pc          = 0;
        m_flush       = 0;
        m_branches    = 0;
        m_mispredicts = 0;
    endtask

    function automatic bit model_ready();
        return (flush_left == 0) && ((mq.size() < DEPTH) || (res_valid && mq.size() > 0));
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit   rdy;
        bit   mis;
        ent_t e;
        rdy = model_ready();
        m_upd_valid = 0; m_upd_taken = 0; m_idx = 0; m_redir = 0; m_pc = 0; m_flush = 0;
        if (flush_left > 0) begin
            flush_left--;
            m_flush = (flush_left > 0);
        end else begin
            mis = 0;
            if (res_valid && mq.size() > 0) begin
                e   = mq.pop_front();
                mis = (e.taken != res_taken) || (res_taken && res_target != e.target);
                if (!e.is_jump) begin
                    m_upd_valid = 1;
                    m_upd_taken = res_taken;
                    m_idx       = e.idx;
                    m_branches++;
                end
                if (mis) begin
                    m_redir = 1;
                    m_pc    = res_taken ? res_target : e.ft;
                    mq.delete();
                    flush_left = FLUSH_CYCLES;
                    m_flush    = 1;
                    m_mispredicts++;
                end
            end
            if (!mis && pred_valid && rdy) begin
                e.is_jump = pred_is_jump;
                e.taken   = pred_taken;
                e.idx     = pred_pht_index;
                e.target  = pred_target;
                e.ft      = pred_fallthrough;
                mq.push_back(e);
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit        pv, jmp, tk;
        bit [2:0]  idx;
        bit [31:0] tgt, ft;
        bit        rv, rt;
        bit [31:0] rtgt;
        bit        e_ready, e_upd, e_updt;
        bit [2:0]  e_idx;
        bit        e_redir;
        bit [31:0] e_pc;
        bit        e_flush;
        int        e_cnt;
    } vec_t;

    function automatic vec_t mk(bit pv, bit jmp, bit tk, bit [2:0] idx, bit [31:0] tgt, bit [31:0] ft,
                                bit rv, bit rt, bit [31:0] rtgt, bit e_ready, bit e_upd, bit e_updt,
                                bit [2:0] e_idx, bit e_redir, bit [31:0] e_pc, bit e_flush, int e_cnt);
        vec_t v;
        v.pv = pv; v.jmp = jmp; v.tk = tk; v.idx = idx; v.tgt = tgt; v.ft = ft;
        v.rv = rv; v.rt = rt; v.rtgt = rtgt; v.e_ready = e_ready; v.e_upd = e_upd;
        v.e_updt = e_updt; v.e_idx = e_idx; v.e_redir = e_redir; v.e_pc = e_pc;
        v.e_flush = e_flush; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t vecs[$];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", pred_ready, 1);
        check("reset_cnt", inflight_cnt, 0);
        check("reset_upd", upd_valid, 0);
        check("reset_redir", redirect_valid, 0);
        check("reset_flush", flush, 0);
        @(negedge clk) rst = 1'b0;
        cycle();

        // correct taken branch
        vecs.push_back(mk(1,0,1,5,'h100,'h10,  0,0,0,      1, 0,0,0, 0,0,      0, 1));
        vecs.push_back(mk(0,0,0,0,0,0,          1,1,'h100,  1, 1,1,5, 0,0,      0, 0));
        // direction mispredict, then flush window ignores push and resolve
        vecs.push_back(mk(1,0,0,2,'h300,'h44,  0,0,0,      1, 0,0,0, 0,0,      0, 1));
        vecs.push_back(mk(0,0,0,0,0,0,          1,1,'h80,   1, 1,1,2, 1,'h80,   1, 0));
        vecs.push_back(mk(1,0,1,1,'h500,'h50,  1,1,'h500,  0, 0,0,0, 0,0,      1, 0));
        vecs.push_back(mk(1,0,1,1,'h500,'h50,  0,0,0,      0, 0,0,0, 0,0,      0, 0));
        // resolve on empty queue
        vecs.push_back(mk(0,0,0,0,0,0,          1,1,'h600,  1, 0,0,0, 0,0,      0, 0));
        // jump target mispredict
        vecs.push_back(mk(1,1,1,3,'h200,'h20,  0,0,0,      1, 0,0,0, 0,0,      0, 1));
        vecs.push_back(mk(0,0,0,0,0,0,          1,1,'h240,  1, 0,0,0, 1,'h240,  1, 0));
        vecs.push_back(mk(0,0,0,0,0,0,          0,0,0,      0, 0,0,0, 0,0,      1, 0));
        vecs.push_back(mk(0,0,0,0,0,0,          0,0,0,      0, 0,0,0, 0,0,      0, 0));
        // fill the queue, hold the 5th, then pop+push while full
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,0,1,3'(i),32'h400+32'(4*i),32'h1000+32'(4*i), 0,0,0, 1, 0,0,0, 0,0, 0, i+1));
        vecs.push_back(mk(1,0,1,4,'h410,'h1010, 0,0,0,      0, 0,0,0, 0,0,      0, 4));
        vecs.push_back(mk(1,0,1,4,'h410,'h1010, 1,1,'h400,  1, 1,1,0, 0,0,      0, 4));
        vecs.push_back(mk(0,0,0,0,0,0,          1,1,'h404,  1, 1,1,1, 0,0,      0, 3));
        // predicted taken, actually not taken: redirect to fall-through
        vecs.push_back(mk(0,0,0,0,0,0,          1,0,0,      1, 1,0,2, 1,'h1008, 1, 0));
        vecs.push_back(mk(0,0,0,0,0,0,          0,0,0,      0, 0,0,0, 0,0,      1, 0));
        vecs.push_back(mk(0,0,0,0,0,0,          0,0,0,      0, 0,0,0, 0,0,      0, 0));
        // correct not-taken branch: target mismatch is irrelevant
        vecs.push_back(mk(1,0,0,6,'h700,'h70,  0,0,0,      1, 0,0,0, 0,0,      0, 1));
        vecs.push_back(mk(0,0,0,0,0,0,          1,0,'h999,  1, 1,0,6, 0,0,      0, 0));

        foreach (vecs[i]) begin
            set_inputs(vecs[i].pv, vecs[i].jmp, vecs[i].tk, vecs[i].idx, vecs[i].tgt, vecs[i].ft,
                       vecs[i].rv, vecs[i].rt, vecs[i].rtgt);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), pred_ready, vecs[i].e_ready);
            cycle();
            check($sformatf("vec%0d_upd_valid", i), upd_valid, vecs[i].e_upd);
            check($sformatf("vec%0d_upd_taken", i), upd_taken, vecs[i].e_updt);
            check($sformatf("vec%0d_upd_idx", i), upd_pht_index, vecs[i].e_idx);
            check($sformatf("vec%0d_redirect", i), redirect_valid, vecs[i].e_redir);
            check($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].e_pc);
            check($sformatf("vec%0d_flush", i), flush, vecs[i].e_flush);
            check($sformatf("vec%0d_cnt", i), inflight_cnt, vecs[i].e_cnt);
        end

        // reset mid-queue with an update pulse pending
        for (int i = 0; i < 3; i++) begin
            set_inputs(1, 0, 1, 3'(i), 'h800, 'h80, 0, 0, 0);
            cycle();
        end
        set_inputs(0, 0, 0, 0, 0, 0, 1, 1, 'h800);
        cycle();
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("midrun_cnt_before", inflight_cnt, 2);
        check("midrun_upd_before", upd_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_cnt", inflight_cnt, 0);
        check("midrun_rst_ready", pred_ready, 1);
        check("midrun_rst_upd", upd_valid, 0);
        check("midrun_rst_redir", redirect_valid, 0);
        check("midrun_rst_flush", flush, 0);
        @(negedge clk) rst = 1'b0;
        cycle();

        // reset mid-flush
        set_inputs(1, 0, 0, 1, 'h900, 'h90, 0, 0, 0);
        cycle();
        set_inputs(0, 0, 0, 0, 0, 0, 1, 1, 'h900);
        cycle();
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("midflush_flush_before", flush, 1);
        #2 rst = 1'b1;
        #1;
        check("midflush_rst_flush", flush, 0);
        check("midflush_rst_redir", redirect_valid, 0);
        check("midflush_rst_ready", pred_ready, 1);
        @(negedge clk) rst = 1'b0;
        cycle();
        check("midflush_after_flush", flush, 0);
        check("midflush_after_ready", pred_ready, 1);

        // randomized traffic against the reference model
        rst = 1'b1;
        model_reset();
        @(negedge clk) rst = 1'b0;
        cycle();
        for (int n = 0; n < 3000; n++) begin
            bit        pv, jmp, tk, rv, rt;
            bit [31:0] tgt, rtgt;
            int        rv_pct;
            rv_pct = ((n / 500) % 2 == 0) ? 45 : 20;
            pv   = ($urandom_range(99) < 60);
            jmp  = ($urandom_range(4) == 0);
            tk   = jmp ? 1'b1 : 1'($urandom_range(1));
            tgt  = 32'h100 * ($urandom_range(2) + 1);
            rv   = ($urandom_range(99) < rv_pct);
            rt   = 1'($urandom_range(1));
            rtgt = 32'h100 * ($urandom_range(2) + 1);
            if (mq.size() > 0 && $urandom_range(4) != 0) begin
                rt   = mq[0].taken;
                rtgt = mq[0].target;
            end
            set_inputs(pv, jmp, tk, 3'($urandom_range(7)), tgt, $urandom, rv, rt, rtgt);
            @(negedge clk);
            check("rnd_ready", pred_ready, model_ready());
            model_step();
            cycle();
            check("rnd_cnt", inflight_cnt, mq.size());
            check("rnd_upd_valid", upd_valid, m_upd_valid);
            check("rnd_upd_taken", upd_taken, m_upd_taken);
            check("rnd_upd_idx", upd_pht_index, m_idx);
            check("rnd_redirect", redirect_valid, m_redir);
            check("rnd_redirect_pc", redirect_pc, m_pc);
            check("rnd_flush", flush, m_flush);
        end
`ifdef BRC_STATS_EN
        check("stat_branches", stat_branches, m_branches);
        check("stat_mispredicts", stat_mispredicts, m_mispredicts);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
